// File: rtl/frame_sequencer.sv
// Per-frame control sequencer for the VGA game loop: clear, draw N_OBJ sprites, collision check,
// frame wait (pausable), erase, coordinate load, with game-over/restart handling.
module frame_sequencer #(
    parameter int unsigned PIXELS       = 250,
    parameter int unsigned N_OBJ        = 2,
    parameter int unsigned WAIT_CYCLES  = 1666666,
    parameter int unsigned CLEAR_CYCLES = 19200,
    localparam int unsigned IDX_MAX     = (CLEAR_CYCLES > PIXELS) ? CLEAR_CYCLES : PIXELS,
    localparam int unsigned IDX_W       = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1,
    localparam int unsigned OBJ_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             touch_edge,
    input  logic             restart,
    input  logic             pause,
    output logic             plot,
    output logic [1:0]       op,
    output logic [OBJ_W-1:0] obj_sel,
    output logic [IDX_W-1:0] pix_idx,
    output logic             move_en,
    output logic             load_coord,
    output logic             game_over,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [IDX_W-1:0]  CLEAR_LAST = IDX_W'(CLEAR_CYCLES - 1);
    localparam logic [IDX_W-1:0]  PIX_LAST   = IDX_W'(PIXELS - 1);
    localparam logic [OBJ_W-1:0]  OBJ_LAST   = OBJ_W'(N_OBJ - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        StClear,
        StDraw,
        StCheck,
        StWait,
        StErase,
        StLoad,
        StOver
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   pix_q, pix_d;
    logic [OBJ_W-1:0]   obj_q, obj_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [15:0]        frame_q, frame_d;

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        obj_d   = obj_q;
        wait_d  = wait_q;
        frame_d = frame_q;
        unique case (state_q)
            StClear: begin
                if (pix_q == CLEAR_LAST) begin
                    pix_d   = '0;
                    state_d = StDraw;
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            StDraw, StErase: begin
                // Pixel index wraps per object; the pass ends on the last pixel of the last object.
                if (pix_q == PIX_LAST) begin
                    pix_d = '0;
                    if (obj_q == OBJ_LAST) begin
                        obj_d   = '0;
                        state_d = (state_q == StDraw) ? StCheck : StLoad;
                    end else begin
                        obj_d = obj_q + 1'b1;
                    end
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            StCheck: state_d = touch_edge ? StOver : StWait;
            StWait: begin
                if (!pause) begin
                    if (wait_q == WAIT_LAST) begin
                        wait_d  = '0;
                        state_d = StErase;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                frame_d = frame_q + 16'd1;
                state_d = StDraw;
            end
            StOver: begin
                if (restart) begin
                    state_d = StClear;
                    pix_d   = '0;
                    obj_d   = '0;
                    wait_d  = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            pix_q   <= '0;
            obj_q   <= '0;
            wait_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            obj_q   <= obj_d;
            wait_q  <= wait_d;
            frame_q <= frame_d;
        end
    end

    // Moore outputs decoded from registered state; counters are zero outside plotting states.
    always_comb begin
        plot       = 1'b0;
        op         = 2'b00;
        move_en    = 1'b0;
        load_coord = 1'b0;
        game_over  = 1'b0;
        unique case (state_q)
            StClear: begin
                plot = 1'b1;
                op   = 2'b10;
            end
            StDraw: begin
                plot    = 1'b1;
                move_en = 1'b1;
            end
            StErase: begin
                plot    = 1'b1;
                op      = 2'b01;
                move_en = 1'b1;
            end
            StWait:  move_en    = 1'b1;
            StLoad:  load_coord = 1'b1;
            StOver:  game_over  = 1'b1;
            default: ;
        endcase
    end

    assign pix_idx   = pix_q;
    assign obj_sel   = obj_q;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with PIXELS=4, N_OBJ=2, WAIT_CYCLES=5, CLEAR_CYCLES=6.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        touch_edge = 1'b0;
    logic        restart = 1'b0;
    logic        pause = 1'b0;
    logic        plot;
    logic [1:0]  op;
    logic [0:0]  obj_sel;
    logic [2:0]  pix_idx;
    logic        move_en;
    logic        load_coord;
    logic        game_over;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;
    int n, nd, ne;

    frame_sequencer #(
        .PIXELS      (4),
        .N_OBJ       (2),
        .WAIT_CYCLES (5),
        .CLEAR_CYCLES(6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .touch_edge(touch_edge),
        .restart   (restart),
        .pause     (pause),
        .plot      (plot),
        .op        (op),
        .obj_sel   (obj_sel),
        .pix_idx   (pix_idx),
        .move_en   (move_en),
        .load_coord(load_coord),
        .game_over (game_over),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until load_coord is sampled high; pause is driven high on sampled cycles p_lo..p_hi.
    task automatic run_to_load(input int p_lo, input int p_hi, output int cyc, output int draws,
                               output int erases);
        cyc = 0; draws = 0; erases = 0;
        do begin
            step();
            cyc++;
            if (plot && op == 2'b00) draws++;
            if (plot && op == 2'b01) erases++;
            pause = (cyc >= p_lo && cyc <= p_hi);
        end while (!load_coord && cyc < 200);
        pause = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        reset = 1'b0;
        check("rst_plot", int'(plot), 1);
        check("rst_op", int'(op), 2);
        check("rst_move", int'(move_en), 0);
        check("rst_load", int'(load_coord), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_frame", int'(frame_cnt), 0);
        check("rst_obj", int'(obj_sel), 0);

        for (int c = 0; c < 6; c++) begin
            check("clr_pix", int'(pix_idx), c);
            check("clr_op", int'(op), 2);
            check("clr_plot", int'(plot), 1);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            check("drw_op", int'(op), 0);
            check("drw_plot", int'(plot), 1);
            check("drw_move", int'(move_en), 1);
            check("drw_obj", int'(obj_sel), i / 4);
            check("drw_pix", int'(pix_idx), i % 4);
            step();
        end
        check("chk_plot", int'(plot), 0);
        check("chk_move", int'(move_en), 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("wait_move", int'(move_en), 1);
            check("wait_plot", int'(plot), 0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            check("ers_op", int'(op), 1);
            check("ers_plot", int'(plot), 1);
            check("ers_obj", int'(obj_sel), i / 4);
            check("ers_pix", int'(pix_idx), i % 4);
            step();
        end
        check("load_pulse", int'(load_coord), 1);
        check("load_frame_pre", int'(frame_cnt), 0);
        step();
        check("load_frame_post", int'(frame_cnt), 1);
        check("load_single", int'(load_coord), 0);

        // Already one cycle into the frame, so 22 steps remain to the next LOAD.
        run_to_load(0, -1, n, nd, ne);
        check("period_a", n, 22);
        run_to_load(0, -1, n, nd, ne);
        check("period_b", n, 23);
        check("draw_cycles", nd, 8);
        check("erase_cycles", ne, 8);
        check("frame_at_3rd", int'(frame_cnt), 2);

        // WAIT occupies sampled cycles 10..14; pausing 12..14 holds the count at 2.
        run_to_load(12, 14, n, nd, ne);
        check("period_paused", n, 26);
        check("frame_after_3", int'(frame_cnt), 3);

        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 5) touch_edge = 1'b1;
        end
        check("chk2_plot", int'(plot), 0);
        check("chk2_over", int'(game_over), 0);
        step();
        touch_edge = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("over_flag", int'(game_over), 1);
            check("over_plot", int'(plot), 0);
            check("over_op", int'(op), 0);
            step();
        end
        check("over_frame", int'(frame_cnt), 4);
        restart = 1'b1;
        step();
        restart = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("rs_clr_pix", int'(pix_idx), c);
            check("rs_clr_op", int'(op), 2);
            check("rs_over", int'(game_over), 0);
            step();
        end
        check("rs_draw_op", int'(op), 0);
        check("rs_draw_pix", int'(pix_idx), 0);
        check("rs_frame", int'(frame_cnt), 4);

        for (int i = 0; i < 6; i++) step();
        check("mid_obj", int'(obj_sel), 1);
        check("mid_pix", int'(pix_idx), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_op", int'(op), 2);
        check("mrst_pix", int'(pix_idx), 0);
        check("mrst_obj", int'(obj_sel), 0);
        check("mrst_frame", int'(frame_cnt), 0);
        check("mrst_load", int'(load_coord), 0);

        force dut.frame_q = 16'hffff;
        #1;
        release dut.frame_q;
        check("wrap_pre", int'(frame_cnt), 65535);
        // From the first CLEAR cycle: 5 clear + 8 draw + 1 check + 5 wait + 8 erase + 1.
        run_to_load(0, -1, n, nd, ne);
        check("first_load", n, 28);
        check("wrap_hold", int'(frame_cnt), 65535);
        step();
        check("wrap_zero", int'(frame_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
